// File: rtl/bin2bcd.sv
//------------------------------------------------------------------------------
// Module   : bin2bcd
// Purpose  : 7-bit binary to 2-digit BCD converter (sequential double dabble),
//            fixed 9-cycle turnaround, with overflow flag for operands > 99.
//            Optional macro BIN2BCD_SAT_EN saturates the digits to 99 on overflow.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd (
   input  logic       clk,
   input  logic       resetb,
   input  logic       start,
   input  logic [6:0] bin,
   output logic       ready,
   output logic       done_tick,
   output logic [3:0] bcd1,
   output logic [3:0] bcd0,
   output logic       ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   logic [6:0] r_bin;
   logic [1:0] r_hun;
   logic [3:0] r_ten;
   logic [3:0] r_one;
   logic [2:0] r_cnt;
   logic       r_ready;
   logic       r_done;
   logic [3:0] r_bcd1;
   logic [3:0] r_bcd0;
   logic       r_ovf;

   logic [3:0] w_ten_adj;
   logic [3:0] w_one_adj;
   logic [1:0] w_hun_nxt;
   logic [3:0] w_ten_nxt;
   logic [3:0] w_one_nxt;
   logic       w_ovf_nxt;

   // The hundreds digit never reaches 5 for a 7-bit operand, so it needs no add-3.
   assign w_ten_adj = (r_ten >= 4'd5) ? r_ten + 4'd3 : r_ten;
   assign w_one_adj = (r_one >= 4'd5) ? r_one + 4'd3 : r_one;
   assign w_hun_nxt = {r_hun[0], w_ten_adj[3]};
   assign w_ten_nxt = {w_ten_adj[2:0], w_one_adj[3]};
   assign w_one_nxt = {w_one_adj[2:0], r_bin[6]};
   // r_hun[1] is always zero before the final shift; folding it in is harmless.
   assign w_ovf_nxt = |{r_hun, w_ten_adj[3]};

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state <= IDLE;
         r_bin   <= 7'd0;
         r_hun   <= 2'd0;
         r_ten   <= 4'd0;
         r_one   <= 4'd0;
         r_cnt   <= 3'd0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_bcd1  <= 4'd0;
         r_bcd0  <= 4'd0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_bin   <= bin;
                  r_hun   <= 2'd0;
                  r_ten   <= 4'd0;
                  r_one   <= 4'd0;
                  r_cnt   <= 3'd7;
                  r_ready <= 1'b0;
                  r_state <= OP;
               end
            end
            OP: begin
               r_hun <= w_hun_nxt;
               r_ten <= w_ten_nxt;
               r_one <= w_one_nxt;
               r_bin <= {r_bin[5:0], 1'b0};
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_ovf   <= w_ovf_nxt;
`ifdef BIN2BCD_SAT_EN
                  if (w_ovf_nxt) begin
                     r_bcd1 <= 4'd9;
                     r_bcd0 <= 4'd9;
                  end else begin
                     r_bcd1 <= w_ten_nxt;
                     r_bcd0 <= w_one_nxt;
                  end
`else
                  r_bcd1 <= w_ten_nxt;
                  r_bcd0 <= w_one_nxt;
`endif
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ready     = r_ready;
   assign done_tick = r_done;
   assign bcd1      = r_bcd1;
   assign bcd0      = r_bcd0;
   assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd.sv
//------------------------------------------------------------------------------
// Module   : tb_bin2bcd
// Purpose  : Directed self-checking bench for bin2bcd (honours BIN2BCD_SAT_EN).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bin2bcd;

   logic       clk    = 1'b0;
   logic       resetb = 1'b0;
   logic       start  = 1'b0;
   logic [6:0] bin    = 7'd0;
   logic       ready;
   logic       done_tick;
   logic [3:0] bcd1;
   logic [3:0] bcd0;
   logic       ovf;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bin2bcd dut (
      .clk       (clk),
      .resetb    (resetb),
      .start     (start),
      .bin       (bin),
      .ready     (ready),
      .done_tick (done_tick),
      .bcd1      (bcd1),
      .bcd0      (bcd0),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Entered at a falling edge with ready=1; returns at the first idle falling edge.
   task automatic run_conv(input logic [6:0] v, input int e1, input int e0,
                           input int eo, input bit hold);
      int k;
      bit seen_ready;
      bin   = v;
      start = 1'b1;
      @(negedge clk);
      if (hold) bin = 7'd13;
      else      start = 1'b0;
      chk("ready_busy", ready, 0);
      k = 1;
      seen_ready = 1'b0;
      while (!done_tick && k < 20) begin
         @(negedge clk);
         k++;
         if (ready) seen_ready = 1'b1;
      end
      start = 1'b0;
      chk("latency", k, 8);
      chk("ready_low", seen_ready, 0);
      chk("bcd1", bcd1, e1);
      chk("bcd0", bcd0, e0);
      chk("ovf", ovf, eo);
      @(negedge clk);
      chk("ready_back", ready, 1);
      chk("done_once", done_tick, 0);
   endtask

   initial begin
      int k;
      int acc;
      int last;
      int t;
      int x1;
      int x0;
      bit seen;

      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_done", done_tick, 0);
      chk("rst_bcd1", bcd1, 0);
      chk("rst_bcd0", bcd0, 0);
      chk("rst_ovf", ovf, 0);
      resetb = 1'b1;
      @(negedge clk);

      run_conv(7'd57, 5, 7, 0, 1'b0);
      run_conv(7'd0, 0, 0, 0, 1'b0);
      run_conv(7'd99, 9, 9, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk("hold_bcd1", bcd1, 9);
      chk("hold_bcd0", bcd0, 9);
      chk("hold_ovf", ovf, 0);
      chk("hold_done", done_tick, 0);

`ifdef BIN2BCD_SAT_EN
      run_conv(7'd127, 9, 9, 1, 1'b0);
`else
      run_conv(7'd127, 2, 7, 1, 1'b0);
`endif

      // start kept high with a different operand while busy
      run_conv(7'd42, 4, 2, 0, 1'b1);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done_tick || !ready) seen = 1'b1;
      end
      chk("ignored_start", seen, 0);
      chk("ign_bcd1", bcd1, 4);
      chk("ign_bcd0", bcd0, 2);

      // reset mid-conversion
      bin   = 7'd88;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 resetb = 1'b0;
      #1;
      chk("abort_ready", ready, 1);
      chk("abort_bcd1", bcd1, 0);
      chk("abort_bcd0", bcd0, 0);
      chk("abort_ovf", ovf, 0);
      chk("abort_done", done_tick, 0);
      @(negedge clk);
      resetb = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_tick) seen = 1'b1;
      end
      chk("abort_nodone", seen, 0);
      run_conv(7'd31, 3, 1, 0, 1'b0);

      // back-to-back sweep with start held high
      start = 1'b1;
      last  = 0;
      for (int v = 0; v < 128; v++) begin
         k = 0;
         while (!ready && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("sw_ready", ready, 1);
         bin = 7'(v);
         acc = cyc;
         if (v > 0) chk("sw_spacing", acc - last, 9);
         last = acc;
         @(negedge clk);
         k = 1;
         while (!done_tick && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("sw_latency", k, 8);
         t  = v % 100;
         x1 = t / 10;
         x0 = t % 10;
`ifdef BIN2BCD_SAT_EN
         if (v > 99) begin
            x1 = 9;
            x0 = 9;
         end
`endif
         chk("sw_bcd1", bcd1, x1);
         chk("sw_bcd0", bcd0, x0);
         chk("sw_ovf", ovf, (v > 99) ? 1 : 0);
         @(negedge clk);
      end
      start = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
